// File: rtl/ip_hdr_pkg.sv
// Shared types for the received-IP-header queue: the packed header layout
// (Ethernet fields followed by the IPv4 base header) and related constants.
package ip_hdr_pkg;

  localparam int IP_HDR_W = 272;
  localparam logic [15:0] IPV4_CSUM_GOOD = 16'hFFFF;

  typedef struct packed {
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] header_checksum;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } ip_hdr_t;

endpackage

// File: rtl/ip_hdr_csum.sv
// Combinational IPv4 header checksum screen: ones-complement sum of the ten
// 16-bit header words, folded, must come out all ones.
module ip_hdr_csum
  import ip_hdr_pkg::*;
(
  input  ip_hdr_t hdr,
  output logic    csum_ok
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        unused_eth;

  // Ten 16-bit words can carry at most 4 bits out, so two folds are enough.
  always_comb begin
    sum = 20'({hdr.version, hdr.ihl, hdr.dscp, hdr.ecn})
        + 20'(hdr.length)
        + 20'(hdr.identification)
        + 20'({hdr.flags, hdr.fragment_offset})
        + 20'({hdr.ttl, hdr.protocol})
        + 20'(hdr.header_checksum)
        + 20'(hdr.source_ip[31:16])
        + 20'(hdr.source_ip[15:0])
        + 20'(hdr.dest_ip[31:16])
        + 20'(hdr.dest_ip[15:0]);
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
  end

  assign csum_ok    = (fold2 == IPV4_CSUM_GOOD);
  assign unused_eth = ^{hdr.eth_dest_mac, hdr.eth_src_mac, hdr.eth_type};

endmodule

// File: rtl/ip_header_fifo.sv
// First-word-fall-through queue of received IP headers with occupancy and
// almost-full reporting. Define IP_HDR_CSUM_CHECK_EN to drop bad-checksum headers.
module ip_header_fifo
  import ip_hdr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  ip_hdr_t                      in_hdr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output ip_hdr_t                      out_hdr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         in_afull,
  output logic [15:0]                  drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake (both sides): a transfer happens on a rising clk edge where
  // valid && ready; valid never waits for ready, and in_ready ignores out_ready.
  ip_hdr_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          csum_ok;

  assign in_ready  = ready_en && (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_hdr   = mem[rd_ptr];
  assign in_afull  = (count >= CW'(AFULL_LEVEL));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && csum_ok;

`ifdef IP_HDR_CSUM_CHECK_EN
  ip_hdr_csum u_csum (
    .hdr     (in_hdr),
    .csum_ok (csum_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (push && !csum_ok && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign csum_ok    = 1'b1;
  assign drop_count = '0;
`endif

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_hdr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ip_header_fifo.md
Name: ip_header_fifo

Overview:
- Parametrised-depth, first-word-fall-through queue for received IP headers (Ethernet side -> FPGA side), with valid/ready on both sides.
- Decouples header-parse timing from payload consumers.
- Adds occupancy reporting, an almost-full flag, and optional IPv4 header-checksum screening that drops corrupt headers before they are queued.

Parameters:
- DEPTH, 4, number of header entries; power of two, >= 2.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which in_afull asserts; range 1..DEPTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  header offered on in_hdr
- in_ready  output  1  queue can accept a header
- in_hdr  input  272  ip_hdr_t packed header: eth_dest_mac, eth_src_mac, eth_type, version, ihl, dscp, ecn, length, identification, flags, fragment_offset, ttl, protocol, header_checksum, source_ip, dest_ip
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_hdr  output  272  head entry (ip_hdr_t)
- count  output  $clog2(DEPTH+1)  current occupancy
- in_afull  output  1  count >= AFULL_LEVEL
- drop_count  output  16  saturating count of headers dropped for bad checksum

Behaviour:
- Reset values (async, rst_n low): pointers = 0, count = 0, drop_count = 0, out_valid = 0, in_afull = 0. in_ready goes to 1 on the first clk edge after release.
- Storage:
  - Registered array with wr_ptr and rd_ptr of width $clog2(DEPTH).
  - Pointers wrap naturally at DEPTH-1 -> 0.
  - Full/empty are derived from count.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count != DEPTH). It must not depend on out_ready, so there is no combinational path.
  - When full and a pop occurs in the same cycle, in_ready stays 0 that cycle.
- out_valid = (count != 0). out_hdr = mem[rd_ptr], muxed directly from storage (FWFT).
- Latency: a header pushed on edge N is visible at out_valid/out_hdr after edge N (one cycle).
- Simultaneous push and pop when non-empty and non-full: count unchanged, both pointers advance.
- When empty, a push is never bypassed to the output in the same cycle.
- count updates: +1 on push only, -1 on pop only. It is never less than 0 or greater than DEPTH.
- out_hdr is held stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all entries immediately; partially handshaken transfers are lost.

Optional Feature:
- Macro: IP_HDR_CSUM_CHECK_EN.
- With the macro defined:
  - The ones-complement sum of the ten 16-bit IPv4 header words (version|ihl|dscp|ecn, length, identification, flags|fragment_offset, ttl|protocol, header_checksum, source_ip hi/lo, dest_ip hi/lo) is computed combinationally on in_hdr, with end-around carry folding.
  - The header is good if the folded sum == 16'hFFFF.
  - A bad header is still handshaken (in_ready unchanged) but is not written; pointers and count are unchanged.
  - drop_count increments by 1 per dropped header and saturates at 16'hFFFF.
- Without the macro: every accepted header is queued and drop_count is tied to 0.

Decomposition:
- Package ip_hdr_pkg holds:
  - ip_hdr_t packed struct, 272 bits, field order as listed under in_hdr, MSB first.
  - IP_HDR_W = 272.
  - IPV4_CSUM_GOOD = 16'hFFFF.
- Sub-module ip_hdr_csum: a combinational checksum checker (ip_hdr_t in, csum_ok out). It is instantiated only under IP_HDR_CSUM_CHECK_EN.

Test Plan:
- Reset and single header:
  - Stimulus: release rst_n, then push one header with source_ip=32'hC0A80001.
  - Required: out_valid is 0 before the edge, 1 one cycle after the push, out_hdr matches the pushed header, count=1.
- Fill and backpressure (DEPTH=4, out_ready=0):
  - Stimulus: push 5 headers.
  - Required: 4 are accepted, in_ready=0 after the 4th, count=4, in_afull=1 from count=3; the 5th is held until a pop.
- Full with simultaneous pop:
  - Stimulus: at count=4, assert out_ready and in_valid.
  - Required: the pop happens, in_ready is 0 that cycle, count becomes 3, then the push is accepted next cycle.
- Wrap-around:
  - Stimulus: stream 10 headers with identification 0..9, out_ready toggling every cycle.
  - Required: output order is 0..9 with no loss or duplication; count returns to 0.
- Checksum screening (macro on):
  - Stimulus: push header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, then the same with checksum B862.
  - Required: the first is queued; the second is accepted but dropped, drop_count=1, count=1.
- Reset mid-stream:
  - Stimulus: with count=3, pulse rst_n low.
  - Required: count=0, out_valid=0 and drop_count=0 asynchronously.
